payload_aggregator: RTL
=======================

// Module: payload_aggregator
// PURPOSE
// Downstream of the receive chain (ether -> bitorder -> firewall, with cksum in parallel).
// - Packs the firewall's 2-bit payload stream into 32-bit words.
// - Holds a frame's words until the cksum verdict arrives.
// - Replays the frame as a burst of 32-bit words only if the CRC passed; otherwise drops it.
// - The game-state logic downstream only ever sees CRC-clean payload words.
// PARAMETERS
// DEPTH       8   max whole words held per frame (buffer entries)
// CK_TIMEOUT  64  cycles to wait for cksum done after frame end before dropping
// PORTS
// clk        in   1   50 MHz RMII reference clock (eth_refclk domain)
// rst        in   1   asynchronous, active-high reset
// axiiv      in   1   payload dibit valid from firewall; high for whole payload, low between frames
// axiid      in   2   payload dibit, already MSB-first order
// done       in   1   cksum verdict strobe, 1-cycle pulse per frame
// kill       in   1   cksum failure; meaningful only in the cycle done=1
// axiov      out  1   word valid; no backpressure
// axiod      out  32  payload word
// axiol      out  1   last word of frame; coincident with final axiov
// drop       out  1   1-cycle pulse: frame discarded (bad CRC, overflow, or timeout)
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, pointers, counters and verdict flags cleared.
// - Reset mid-frame: rest of that frame is ignored until axiiv has been seen low.
// - Packing:
//   - First dibit of a word lands in bits [31:30], the 16th in [1:0].
//   - 4-bit dibit counter; on the 16th dibit the word is written to buf[wr_ptr], wr_ptr++.
//   - A trailing partial word (<16 dibits at frame end) is silently discarded.
// - Verdict latch:
//   - done may arrive before, during or after the end of firewall output (cksum sees the frame earlier).
//   - Whenever done=1 in COLLECT or WAIT_CK, set ck_seen=1 and ck_bad=kill.
//   - In IDLE, done is ignored.
// - FSM:
//   - IDLE:    axiiv=1 -> COLLECT; that same dibit is captured.
//   - COLLECT: axiiv=0 -> WAIT_CK, timer cleared.
//     - A word arriving when wr_ptr==DEPTH sets ovf; the word is not stored.
//   - WAIT_CK: the next state is resolved in priority order:
//     1. ck_seen&ck_bad, or ovf, or wr_ptr==0 -> DROP.
//     2. ck_seen&!ck_bad -> DRAIN. Also taken in the same cycle when done&!kill arrives.
//     3. Timer reaches CK_TIMEOUT-1 -> DROP.
//   - DRAIN:
//     - One word per cycle: axiov=1, axiod=buf[rd_ptr], rd_ptr++.
//     - axiol=1 when rd_ptr==wr_ptr-1; next state IDLE with pointers and flags cleared.
//   - DROP: drop=1 for exactly one cycle; pointers and flags cleared; -> IDLE.
// - Latency:
//   - First word appears on the cycle after the transition into DRAIN.
//   - A frame of N words occupies N consecutive axiov cycles.
// - Frame arriving when not IDLE (axiiv=1 in DRAIN, DROP, or WAIT_CK):
//   - The whole frame is ignored until axiiv is seen low.
//   - Its done strobe is ignored.
//   - Cannot occur at RMII interframe gap >=48 cycles with DEPTH<=16; it must still be safe.
// - Pointers are $clog2(DEPTH)+1 bits wide, so the full case (wr_ptr==DEPTH) is distinguishable.
// - Pointers never wrap within a frame.
// - axiod holds its last value when axiov=0. The checker compares axiod only while axiov=1.
// STRUCTURE
// - Shared package rx_pkg:
//   - typedef enum {IDLE, COLLECT, WAIT_CK, DRAIN, DROP} agg_state_t.
//   - localparam WORD_W=32, DIBITS_PER_WORD=16.
// - One sub-module, dibit_packer:
//   - Inputs: axiiv/axiid.
//   - Outputs: word, word_valid pulse, and partial-count; clears when axiiv=0.
// - Word buffer: plain register array inside payload_aggregator; no FIFO IP.
// TESTING
// 1. Good frame: 64 dibits giving words 0xDEADBEEF,0x01234567,0x89ABCDEF,0x0F0F0F0F.
//    done&!kill 10 cycles after axiiv falls.
//    -> 4 consecutive axiov words in order; axiol on the 4th; drop stays 0.
// 2. Bad CRC: same frame, done with kill=1 -> no axiov; drop pulses once.
// 3. Early verdict: done&!kill 5 cycles before axiiv falls, 2-word frame + 7 spare dibits.
//    -> 2 words output; partial word discarded.
// 4. Overflow: 9 whole words with DEPTH=8, good CRC -> no axiov; one drop pulse.
// 5. Timeout: 1-word frame, done never asserted.
//    -> drop pulses CK_TIMEOUT cycles after axiiv falls; IDLE after.
// 6. Async rst asserted mid-COLLECT:
//    - Outputs go to 0 immediately.
//    - The remainder of that frame produces nothing.
//    - The next good frame is output correctly.

Source files
------------

// File: rtl/rx_pkg.sv
// rtl/rx_pkg.sv - shared types and constants for the receive-side payload path
package rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    WAIT_CK,
    DRAIN,
    DROP
  } agg_state_t;

  localparam int WORD_W          = 32;
  localparam int DIBITS_PER_WORD = 16;
  localparam int DIBIT_CNT_W     = $clog2(DIBITS_PER_WORD);

endpackage

// File: rtl/payload_aggregator_if.sv
// rtl/payload_aggregator_if.sv - dibit-in / word-out bundle of the payload aggregator
interface payload_aggregator_if;
  import rx_pkg::*;

  logic              axiiv;
  logic [1:0]        axiid;
  logic              done;
  logic              kill;
  logic              axiov;
  logic [WORD_W-1:0] axiod;
  logic              axiol;
  logic              drop;

  modport master (
    output axiiv, axiid, done, kill,
    input  axiov, axiod, axiol, drop
  );

  modport slave (
    input  axiiv, axiid, done, kill,
    output axiov, axiod, axiol, drop
  );

endinterface

// File: rtl/dibit_packer.sv
// rtl/dibit_packer.sv - shifts MSB-first dibits into 32-bit words
module dibit_packer
  import rx_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   axiiv,
  input  logic [1:0]             axiid,
  output logic [WORD_W-1:0]      word,
  output logic                   word_valid,
  output logic [DIBIT_CNT_W-1:0] partial_cnt
);

  // Only the 15 earlier dibits are stored; the 16th completes the word combinationally.
  logic [WORD_W-3:0]      shreg;
  logic [DIBIT_CNT_W-1:0] cnt;

  assign word        = {shreg, axiid};
  assign word_valid  = axiiv && (cnt == DIBIT_CNT_W'(DIBITS_PER_WORD - 1));
  assign partial_cnt = cnt;

  // Shift dibits in while valid; a gap discards any partial word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (axiiv) begin
      shreg <= word[WORD_W-3:0];
      cnt   <= cnt + 1'b1;
    end else begin
      cnt   <= '0;
    end
  end

endmodule

// File: rtl/payload_aggregator.sv
// rtl/payload_aggregator.sv - buffers a frame's payload words and replays them only on a clean CRC
module payload_aggregator
  import rx_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int CK_TIMEOUT = 64
) (
  input logic                 clk,
  input logic                 rst,
  payload_aggregator_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH) + 1;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int TMR_W = $clog2(CK_TIMEOUT);

  agg_state_t             state;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [TMR_W-1:0]       timer;
  logic                   ck_seen;
  logic                   ck_bad;
  logic                   ovf;
  logic                   blocked;
  logic                   pk_valid;
  logic [WORD_W-1:0]      pk_word;
  logic                   pk_word_valid;
  logic [DIBIT_CNT_W-1:0] unused_partial_cnt;
  logic [WORD_W-1:0]      buf_mem [DEPTH];

  // Dibits are accepted only for a frame that started cleanly in IDLE.
  assign pk_valid = bus.axiiv && (((state == IDLE) && !blocked) || (state == COLLECT));

  dibit_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .axiiv       (pk_valid),
    .axiid       (bus.axiid),
    .word        (pk_word),
    .word_valid  (pk_word_valid),
    .partial_cnt (unused_partial_cnt)
  );

  // Word storage; a word arriving with the buffer full is flagged below instead.
  always_ff @(posedge clk) begin
    if (pk_word_valid && (wr_ptr != PTR_W'(DEPTH))) begin
      buf_mem[wr_ptr[IDX_W-1:0]] <= pk_word;
    end
  end

  // Frame FSM: collect, await verdict, then replay or discard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      timer   <= '0;
      ck_seen <= 1'b0;
      ck_bad  <= 1'b0;
      ovf     <= 1'b0;
      blocked <= 1'b1;
      bus.axiov <= 1'b0;
      bus.axiod <= '0;
      bus.axiol <= 1'b0;
      bus.drop  <= 1'b0;
    end else begin
      bus.axiov <= 1'b0;
      bus.axiol <= 1'b0;
      bus.drop  <= 1'b0;

      // A frame that cannot be taken, or was cut by reset, is skipped until its gap.
      if (!bus.axiiv) begin
        blocked <= 1'b0;
      end else if (state inside {WAIT_CK, DRAIN, DROP}) begin
        blocked <= 1'b1;
      end

      if (pk_word_valid) begin
        if (wr_ptr == PTR_W'(DEPTH)) begin
          ovf <= 1'b1;
        end else begin
          wr_ptr <= wr_ptr + 1'b1;
        end
      end

      if (bus.done && (state inside {COLLECT, WAIT_CK})) begin
        ck_seen <= 1'b1;
        ck_bad  <= bus.kill;
      end

      case (state)
        IDLE: begin
          if (bus.axiiv && !blocked) state <= COLLECT;
        end
        COLLECT: begin
          if (!bus.axiiv) begin
            state <= WAIT_CK;
            timer <= '0;
          end
        end
        WAIT_CK: begin
          if ((ck_seen && ck_bad) || ovf || (wr_ptr == '0)) begin
            state    <= DROP;
            bus.drop <= 1'b1;
          end else if ((ck_seen && !ck_bad) || (bus.done && !bus.kill)) begin
            state  <= DRAIN;
            rd_ptr <= '0;
          end else if (timer == TMR_W'(CK_TIMEOUT - 1)) begin
            state    <= DROP;
            bus.drop <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DRAIN: begin
          bus.axiov <= 1'b1;
          bus.axiod <= buf_mem[rd_ptr[IDX_W-1:0]];
          rd_ptr    <= rd_ptr + 1'b1;
          if (rd_ptr == wr_ptr - 1'b1) begin
            bus.axiol <= 1'b1;
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            timer     <= '0;
            ck_seen   <= 1'b0;
            ck_bad    <= 1'b0;
            ovf       <= 1'b0;
          end
        end
        DROP: begin
          state   <= IDLE;
          wr_ptr  <= '0;
          rd_ptr  <= '0;
          timer   <= '0;
          ck_seen <= 1'b0;
          ck_bad  <= 1'b0;
          ovf     <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
